// File: rtl/gp_out_uart_tx.sv
// Sends each change of the PIO output byte as an 8N1 UART frame; txd falls 2 cycles after a change.
// Changes queue in a small FIFO while a frame runs or enable=0; a change arriving while full is dropped and flagged.
module gp_out_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       in_port,
   input  logic             enable,
   input  logic             clear_overflow,
   output logic             txd,
   output logic             busy,
   output logic [CNT_W-1:0] fifo_count,
   output logic             overflow
);
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state, state_nxt;
   logic [7:0]        prev_q;
   logic [7:0]        shift, shift_nxt;
   logic [7:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [BAUD_W-1:0] baud_cnt, baud_nxt;
   logic [2:0]        bit_cnt, bit_nxt;
   logic              push, pop, full, accept, drop, bit_end, txd_nxt;

   assign push    = (in_port != prev_q);
   assign full    = (fifo_count == FULL_CNT);
   assign accept  = push && (!full || pop);
   assign drop    = push && full && !pop;
   assign bit_end = (baud_cnt == BAUD_LAST);

   always_comb begin
      state_nxt = state;
      shift_nxt = shift;
      baud_nxt  = baud_cnt;
      bit_nxt   = bit_cnt;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (enable && fifo_count != '0) begin
               pop       = 1'b1;
               shift_nxt = mem[rd_ptr];
               bit_nxt   = 3'd0;
               baud_nxt  = '0;
               state_nxt = START;
            end
         end
         START: begin
            if (bit_end) begin
               baud_nxt  = '0;
               state_nxt = DATA;
            end else begin
               baud_nxt = baud_cnt + BAUD_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_nxt  = '0;
               shift_nxt = shift >> 1;
               bit_nxt   = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nxt = STOP;
            end else begin
               baud_nxt = baud_cnt + BAUD_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_nxt  = '0;
               state_nxt = IDLE;
            end else begin
               baud_nxt = baud_cnt + BAUD_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // txd is derived from the next state so the pin comes straight off a flop.
   always_comb begin
      case (state_nxt)
         START:   txd_nxt = 1'b0;
         DATA:    txd_nxt = shift_nxt[0];
         default: txd_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         shift      <= 8'h00;
         baud_cnt   <= '0;
         bit_cnt    <= 3'd0;
         prev_q     <= 8'h00;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
         txd        <= 1'b1;
         busy       <= 1'b0;
      end else begin
         state    <= state_nxt;
         shift    <= shift_nxt;
         baud_cnt <= baud_nxt;
         bit_cnt  <= bit_nxt;
         prev_q   <= in_port;
         txd      <= txd_nxt;
         busy     <= (state_nxt != IDLE);
         if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
         case ({accept, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (drop)                overflow <= 1'b1;
         else if (clear_overflow) overflow <= 1'b0;
      end
   end

   // When full, a same-cycle pop reads the head before this write replaces it.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= in_port;
   end
endmodule

// File: tb/tb_gp_out_uart_tx.sv
// Bench for gp_out_uart_tx: queue/frame-timer model checked every cycle, plus directed literal checks.
module tb_gp_out_uart_tx;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] in_port;
   logic       enable;
   logic       clear_overflow;
   logic       txd;
   logic       busy;
   logic [2:0] fifo_count;
   logic       overflow;

   int n_cmp = 0;
   int n_bad = 0;

   gp_out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .in_port(in_port), .enable(enable),
      .clear_overflow(clear_overflow), .txd(txd), .busy(busy),
      .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Model: a byte queue, a sticky flag and a frame timer k counting cycles since the start bit.
   logic [7:0] m_q[$];
   logic [7:0] m_sent[$];
   logic [7:0] m_prev = 8'h00;
   logic [7:0] m_byte = 8'h00;
   bit         m_active = 1'b0;
   int         m_k = 0;
   bit         m_ovf = 1'b0;

   function automatic bit frame_bit(input logic [7:0] b, input int k);
      int idx;
      idx = k / CPB;
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return b[idx-1];
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      bit drop;
      drop = 1'b0;
      if (!reset_n) begin
         m_q.delete();
         m_prev = 8'h00;
         m_active = 1'b0;
         m_k = 0;
         m_ovf = 1'b0;
      end else begin
         if (m_active) begin
            m_k++;
            if (m_k == FRAME) m_active = 1'b0;
         end else if (enable && m_q.size() != 0) begin
            m_byte = m_q.pop_front();
            m_sent.push_back(m_byte);
            m_active = 1'b1;
            m_k = 0;
         end
         if (in_port != m_prev) begin
            if (m_q.size() < DEPTH) m_q.push_back(in_port);
            else drop = 1'b1;
         end
         if (drop) m_ovf = 1'b1;
         else if (clear_overflow) m_ovf = 1'b0;
         m_prev = in_port;
      end
   end

   always @(negedge clk) begin
      check("txd", int'(txd), int'(m_active ? frame_bit(m_byte, m_k) : 1'b1));
      check("busy", int'(busy), int'(m_active));
      check("fifo_count", int'(fifo_count), m_q.size());
      check("overflow", int'(overflow), int'(m_ovf));
   end

   initial begin
      bit exp_a5 [10];
      int base;
      exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      reset_n = 1'b0; in_port = 8'h00; enable = 1'b1; clear_overflow = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_txd", int'(txd), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_count", int'(fifo_count), 0);
      check("rst_ovf", int'(overflow), 0);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      check("zero_first_count", int'(fifo_count), 0);
      check("zero_first_busy", int'(busy), 0);
      check("zero_first_sent", m_sent.size(), 0);

      // 00 -> A5: push on the first edge, start bit after the second.
      in_port = 8'hA5;
      @(negedge clk);
      check("a5_push_txd", int'(txd), 1);
      check("a5_push_count", int'(fifo_count), 1);
      @(negedge clk);
      for (int j = 0; j < FRAME; j++) begin
         check("a5_txd", int'(txd), int'(exp_a5[j / CPB]));
         check("a5_busy", int'(busy), 1);
         @(negedge clk);
      end
      check("a5_end_busy", int'(busy), 0);
      check("a5_end_count", int'(fifo_count), 0);

      in_port = 8'h3C;
      repeat (3) @(negedge clk);
      in_port = 8'h3C;
      repeat (50) @(negedge clk);
      check("3c_frames", m_sent.size(), 2);
      check("3c_byte", int'(m_sent[1]), 8'h3C);

      // Fill while disabled, fifth change overflows.
      reset_n = 1'b0; enable = 1'b0; in_port = 8'h00;
      @(negedge clk);
      reset_n = 1'b1;
      base = m_sent.size();
      for (int v = 1; v <= 5; v++) begin
         in_port = 8'(v);
         @(negedge clk);
      end
      check("ovf_count", int'(fifo_count), 4);
      check("ovf_flag", int'(overflow), 1);
      enable = 1'b1;
      repeat (4 * (FRAME + 1) + 10) @(negedge clk);
      check("ovf_nframes", m_sent.size(), base + 4);
      for (int i = 0; i < 4; i++) check("ovf_order", int'(m_sent[base + i]), i + 1);
      check("ovf_sticky", int'(overflow), 1);
      clear_overflow = 1'b1;
      @(negedge clk);
      clear_overflow = 1'b0;
      check("ovf_cleared", int'(overflow), 0);

      // Full in IDLE; a change on the load edge is accepted.
      enable = 1'b0;
      base = m_sent.size();
      foreach (exp_a5[i]) if (i < 4) begin
         in_port = 8'(8'h10 * (i + 1));
         @(negedge clk);
      end
      check("full_count", int'(fifo_count), 4);
      enable = 1'b1; in_port = 8'h50;
      @(negedge clk);
      check("load_push_count", int'(fifo_count), 4);
      check("load_push_ovf", int'(overflow), 0);
      check("load_push_busy", int'(busy), 1);
      in_port = 8'h60; clear_overflow = 1'b1;
      @(negedge clk);
      clear_overflow = 1'b0;
      check("drop_beats_clear", int'(overflow), 1);
      clear_overflow = 1'b1;
      @(negedge clk);
      clear_overflow = 1'b0;
      check("clear_alone", int'(overflow), 0);
      repeat (5 * (FRAME + 1) + 10) @(negedge clk);
      check("full_nframes", m_sent.size(), base + 5);
      check("full_last", int'(m_sent[base + 4]), 8'h50);

      // Reset in the middle of data bit 3.
      in_port = 8'h07;
      @(negedge clk);
      in_port = 8'h08;
      @(negedge clk);
      repeat (17) @(negedge clk);
      check("mid_txd", int'(txd), 0);
      check("mid_busy", int'(busy), 1);
      check("mid_count", int'(fifo_count), 1);
      #1 reset_n = 1'b0; in_port = 8'h00;
      #1;
      check("arst_txd", int'(txd), 1);
      check("arst_busy", int'(busy), 0);
      check("arst_count", int'(fifo_count), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      base = m_sent.size();
      in_port = 8'h81;
      repeat (FRAME + 5) @(negedge clk);
      check("post_rst_frames", m_sent.size(), base + 1);
      check("post_rst_byte", int'(m_sent[base]), 8'h81);

      // Drop enable during the start bit of 11 with 22 queued.
      base = m_sent.size();
      in_port = 8'h11;
      @(negedge clk);
      in_port = 8'h22;
      @(negedge clk);
      enable = 1'b0;
      repeat (FRAME + 5) @(negedge clk);
      check("hold_busy", int'(busy), 0);
      check("hold_count", int'(fifo_count), 1);
      check("hold_frames", m_sent.size(), base + 1);
      enable = 1'b1;
      @(negedge clk);
      check("resume_busy", int'(busy), 1);
      check("resume_txd", int'(txd), 0);
      repeat (FRAME + 5) @(negedge clk);
      check("resume_byte", int'(m_sent[base + 1]), 8'h22);

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(23) == 0) in_port = 8'($urandom);
         enable = ($urandom_range(7) != 0);
         clear_overflow = ($urandom_range(49) == 0);
         @(negedge clk);
      end
      enable = 1'b1; clear_overflow = 1'b0;
      repeat (5 * (FRAME + 1)) @(negedge clk);
      check("drain_count", int'(fifo_count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
